cnu_compress: RTL and testbench
===============================

CNU_COMPRESS -- requirements
Module: cnu_compress

Interface
REQ-001 Parameter Wc, default 32, number of messages per check-node row.
REQ-002 Parameter Wcbits, default 5, width of the position index (ceil log2 Wc).
REQ-003 Parameter W, default 10, two's-complement message width; Wabs = W-1.
REQ-004 Parameter ECOMPSIZE, default 2*(W-1)+Wcbits+Wc, compressed row width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_msg holds a valid message.
REQ-008 in_ready  output  1  block accepts in_msg this cycle.
REQ-009 in_msg  input  W  two's-complement variable-to-check message.
REQ-010 out_valid  output  1  Ecomp holds a complete row.
REQ-011 out_ready  input  1  downstream recovery stage consumes Ecomp.
REQ-012 Ecomp  output  ECOMPSIZE  packed {Min1, Min2, Pos, UpdatedSign}, MSB first.

Function
REQ-013 Transfer occurs on a rising edge with in_valid=1 and in_ready=1; message index = number of prior transfers in the current row (0..Wc-1).
REQ-014 Magnitude = |in_msg| saturated to 2^Wabs-1 (most-negative input maps to 511 for W=10); sign = in_msg[W-1].
REQ-015 At row start, Min1 = Min2 = 2^Wabs-1 and Pos = 0.
REQ-016 Per transfer: if mag < Min1 then Min2<=Min1, Min1<=mag, Pos<=index; else if mag < Min2 then Min2<=mag; else no change.
REQ-017 Ties: magnitude equal to Min1 updates Min2 only; Pos keeps the first index achieving the minimum.
REQ-018 Sign register bit i <= sign of message i; parity <= XOR of all Wc signs.
REQ-019 UpdatedSign[i] = signreg[i] XOR parity, i.e., the extrinsic sign per position.
REQ-020 FSM states ACCUM and DONE; reset enters ACCUM with index 0.
REQ-021 ACCUM: in_ready=1, out_valid=0; on transfer with index Wc-1, go to DONE.
REQ-022 DONE: in_ready=0, out_valid=1; Ecomp is valid the cycle after the last transfer (latency 1) and holds stable until handshake.
REQ-023 DONE with out_ready=1: go to ACCUM, clear index, re-initialise Min1/Min2/Pos/sign/parity for the next row.
REQ-024 in_valid gaps in ACCUM stall accumulation with no state change; out_ready is ignored in ACCUM.
REQ-025 Index counter wraps only via the DONE->ACCUM transition; there are no partial rows.

Reset
REQ-026 rst low asynchronously forces: state ACCUM, index 0, out_valid 0, Min1=Min2=2^Wabs-1, Pos 0, signreg 0, parity 0, Ecomp as packed from these.
REQ-027 Reset mid-row discards the partial row; the first transfer after release is index 0.

Structure
REQ-028 Wc, Wcbits, W, Wabs, ECOMPSIZE and the FSM state encoding reside in the shared package ldpc_pkg, which the recovery unit also uses.
REQ-029 One sub-module, abs_sat (W-bit two's complement -> sign plus saturated Wabs-bit magnitude), is instantiated once.
REQ-030 Ecomp packing matches the recovery-stage unpack order exactly: Min1 at MSBs, then Min2, Pos, and UpdatedSign at LSBs, with bit i = index i.

Verification
REQ-031 All +100 except idx7=-3 and idx20=+5 -> Min1=3, Min2=5, Pos=7, UpdatedSign=0xFFFFFF7F.
REQ-032 idx4=+2, idx9=-2, rest +50 -> Min1=2, Min2=2, Pos=4, UpdatedSign=0x00000200 XOR 0xFFFFFFFF = 0xFFFFFDFF.
REQ-033 All 32 inputs=-512 -> Min1=511, Min2=511, Pos=0, parity 0, UpdatedSign=0xFFFFFFFF.
REQ-034 out_ready held low 10 cycles after a row -> out_valid=1, in_ready=0, Ecomp stable; on release, the next 32-message row is correct.
REQ-035 rst asserted after 15 transfers, then a full row of REQ-031 data -> out_valid stays 0 until the 32nd post-reset transfer; result matches REQ-031.
REQ-036 Random in_valid gaps (about 50%) on the REQ-031 row -> identical Ecomp, out_valid one cycle after the 32nd transfer.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants and types, used by the check-node
// compression stage and the downstream recovery unit.
package ldpc_pkg;

  // Messages per check-node row
  localparam int Wc        = 32;
  // Width of a position index (ceil log2 Wc)
  localparam int Wcbits    = 5;
  // Two's-complement message width
  localparam int W         = 10;
  // Magnitude width after sign removal
  localparam int Wabs      = W - 1;
  // Compressed row width: {Min1, Min2, Pos, UpdatedSign}
  localparam int ECOMPSIZE = 2 * Wabs + Wcbits + Wc;

  // Row controller states, shared with the recovery unit
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } cnu_state_e;

endpackage : ldpc_pkg

// File: rtl/cnu_compress_abs_sat.sv
// Splits a two's-complement message into its sign bit and a saturated
// magnitude. The most-negative code has no positive counterpart in W-1
// bits, so it is clamped to the largest magnitude.
module abs_sat #(
  parameter int W = ldpc_pkg::W
) (
  input  logic [W-1:0] msg,
  output logic         sign,
  output logic [W-2:0] mag
);

  logic [W-1:0] negated;

  // Conditional negate, then clamp the single overflow case
  always_comb begin
    negated = ~msg + 1'b1;
    sign    = msg[W-1];
    if (!msg[W-1]) begin
      mag = msg[W-2:0];
    end else if (negated[W-1]) begin
      // Negating the most-negative code leaves the sign bit set
      mag = '1;
    end else begin
      mag = negated[W-2:0];
    end
  end

endmodule : abs_sat

// File: rtl/cnu_compress.sv
// Check-node compression: accumulates one row of Wc variable-to-check
// messages and presents the compressed form {Min1, Min2, Pos, UpdatedSign}
// to the recovery stage with a valid/ready handshake.
module cnu_compress
  import ldpc_pkg::cnu_state_e, ldpc_pkg::ACCUM, ldpc_pkg::DONE;
#(
  parameter int Wc        = ldpc_pkg::Wc,
  parameter int Wcbits    = ldpc_pkg::Wcbits,
  parameter int W         = ldpc_pkg::W,
  parameter int ECOMPSIZE = 2 * (W - 1) + Wcbits + Wc
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_msg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ECOMPSIZE-1:0] Ecomp
);

  localparam int Wabs = W - 1;
  localparam logic [Wabs-1:0]   MAG_MAX   = '1;
  localparam logic [Wcbits-1:0] LAST_IDX  = Wcbits'(Wc - 1);

  cnu_state_e        state;
  cnu_state_e        state_nxt;

  logic [Wcbits-1:0] idx;
  logic [Wabs-1:0]   min1;
  logic [Wabs-1:0]   min2;
  logic [Wcbits-1:0] pos;
  logic [Wc-1:0]     signreg;
  logic              parity;

  logic              msg_sign;
  logic [Wabs-1:0]   msg_mag;
  logic              xfer;
  logic              row_taken;
  logic [Wc-1:0]     updated_sign;

  abs_sat #(
    .W (W)
  ) u_abs_sat (
    .msg  (in_msg),
    .sign (msg_sign),
    .mag  (msg_mag)
  );

  assign xfer      = in_valid && in_ready;
  assign row_taken = (state == DONE) && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (xfer && (idx == LAST_IDX)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Row accumulator: two smallest magnitudes, argmin, signs and parity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      min1    <= MAG_MAX;
      min2    <= MAG_MAX;
      pos     <= '0;
      signreg <= '0;
      parity  <= 1'b0;
    end else if (row_taken) begin
      // Row consumed downstream: prime for the next row
      idx     <= '0;
      min1    <= MAG_MAX;
      min2    <= MAG_MAX;
      pos     <= '0;
      signreg <= '0;
      parity  <= 1'b0;
    end else if (xfer) begin
      // NOTE: non-blocking assignments here mean the min1/min2 comparisons
      // below all see the pre-edge values, so Min2 <= old Min1 is correct.
      if (msg_mag < min1) begin
        min2 <= min1;
        min1 <= msg_mag;
        pos  <= idx;
      end else if (msg_mag < min2) begin
        min2 <= msg_mag;
      end
      signreg[idx] <= msg_sign;
      parity       <= parity ^ msg_sign;
      // Index holds at the last position until the row is taken
      if (idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Extrinsic sign per position: own sign removed from the row parity
  assign updated_sign = signreg ^ {Wc{parity}};

  // Packing order matches the recovery-stage unpack: Min1 at the MSBs
  assign Ecomp = {min1, min2, pos, updated_sign};

endmodule : cnu_compress

// File: tb/tb_cnu_compress.sv
// Directed testbench for cnu_compress: hand-computed rows, backpressure,
// mid-row reset and in_valid gaps.
module tb_cnu_compress;

  localparam int Wc        = 32;
  localparam int Wcbits    = 5;
  localparam int W         = 10;
  localparam int ECOMPSIZE = 2 * (W - 1) + Wcbits + Wc;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_msg;
  logic                 out_valid;
  logic                 out_ready;
  logic [ECOMPSIZE-1:0] Ecomp;

  logic [W-1:0]         row [Wc];
  int                   n_tests;
  int                   n_fail;

  cnu_compress #(
    .Wc        (Wc),
    .Wcbits    (Wcbits),
    .W         (W),
    .ECOMPSIZE (ECOMPSIZE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Ecomp     (Ecomp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [8:0] m1,
                                       input logic [8:0] m2,
                                       input logic [4:0] p,
                                       input logic [31:0] us);
    return {9'd0, m1, m2, p, us};
  endfunction

  // Fill the row with one value
  task automatic fill_row(input logic [W-1:0] v);
    for (int i = 0; i < Wc; i++) row[i] = v;
  endtask

  // Drive one message and let it transfer on the next rising edge
  task automatic send_msg(input logic [W-1:0] m, input bool_last_check);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_msg   = m;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    if (bool_last_check) check("no_early_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send the first n entries of row, optionally with random idle gaps
  task automatic send_row(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(1, 0) == 1)) @(negedge clk);
      send_msg(row[i], (i == n - 1) && (n == Wc));
    end
  endtask

  // Check the finished row one cycle after the last transfer, then take it
  task automatic check_and_take(input string tag, input logic [63:0] exp);
    @(negedge clk);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_ecomp"},     64'(Ecomp),     exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_released"}, 64'(out_valid), 64'd0);
    check({tag, "_reinit"},   64'(Ecomp), pack(9'd511, 9'd511, 5'd0, 32'h0));
  endtask

  task automatic load_row_031();
    fill_row(10'd100);
    row[7]  = 10'h3FD;  // -3
    row[20] = 10'd5;
  endtask

  task automatic load_row_032();
    fill_row(10'd50);
    row[4] = 10'd2;
    row[9] = 10'h3FE;   // -2
  endtask

  logic [63:0] exp_031;
  logic [63:0] exp_032;
  logic [63:0] exp_033;
  logic [63:0] held;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_msg    = '0;
    out_ready = 1'b0;

    exp_031 = pack(9'd3, 9'd5, 5'd7, 32'hFFFF_FF7F);
    exp_032 = pack(9'd2, 9'd2, 5'd4, 32'hFFFF_FDFF);
    exp_033 = pack(9'd511, 9'd511, 5'd0, 32'hFFFF_FFFF);

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_ecomp",     64'(Ecomp), pack(9'd511, 9'd511, 5'd0, 32'h0));
    @(negedge clk);
    rst = 1'b1;

    // Single negative minimum, distinct second minimum
    load_row_031();
    send_row(Wc, 1'b0);
    check_and_take("r031", exp_031);

    // Tie between Min1 and Min2; out_ready high during ACCUM is ignored
    load_row_032();
    out_ready = 1'b1;
    send_row(Wc, 1'b0);
    out_ready = 1'b0;
    check_and_take("r032", exp_032);

    // Saturation of the most-negative code; even parity
    fill_row(10'h200);
    send_row(Wc, 1'b0);
    check_and_take("r033", exp_033);

    // Backpressure: hold the result while offering a stray message
    load_row_031();
    send_row(Wc, 1'b0);
    @(negedge clk);
    held     = 64'(Ecomp);
    in_valid = 1'b1;
    in_msg   = 10'd1;
    repeat (10) @(negedge clk);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready",  64'(in_ready),  64'd0);
    check("bp_stable",    64'(Ecomp),     held);
    check("bp_ecomp",     64'(Ecomp),     exp_031);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    load_row_032();
    send_row(Wc, 1'b0);
    check_and_take("bp_next", exp_032);

    // Reset after 15 transfers discards the partial row
    fill_row(10'h3FF);  // -1: would set Min1=1 and all signs if kept
    send_row(15, 1'b0);
    rst = 1'b0;
    #2;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ecomp", 64'(Ecomp), pack(9'd511, 9'd511, 5'd0, 32'h0));
    @(negedge clk);
    rst = 1'b1;
    load_row_031();
    send_row(Wc, 1'b0);
    check_and_take("post_rst", exp_031);

    // Random in_valid gaps give the same result and latency
    load_row_031();
    send_row(Wc, 1'b1);
    check_and_take("gaps", exp_031);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_cnu_compress
